// File: rtl/tob_pkg.sv
// Shared screen geometry and drawer FSM encodings for the block game.
// The x position register takes its X_MAX from here.
package tob_pkg;
  localparam int SCREEN_COLS = 160;
  localparam int SCREEN_ROWS = 120;
  localparam int X_MAX       = SCREEN_COLS - 1;
  localparam int BLOCK_H_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ERASE  = 2'd1,
    DRAW   = 2'd2,
    FINISH = 2'd3
  } state_t;
endpackage

// File: rtl/rect_scanner.sv
// Walks a width x height rectangle one pixel per cycle, x inner and y outer.
// go (re)loads the walk from the top-left corner; coordinates are 9 bits wide so they never wrap.
module rect_scanner (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic [7:0] base_x,
  input  logic [6:0] base_y,
  input  logic [7:0] width,
  input  logic [7:0] height,
  output logic [8:0] col,
  output logic [8:0] row,
  output logic       active,
  output logic       last
);
  logic [7:0] col_off;
  logic [7:0] row_off;
  logic       col_end;
  logic       row_end;

  assign col_end = (col_off == width - 8'd1);
  assign row_end = (row_off == height - 8'd1);
  assign col     = {1'b0, base_x} + {1'b0, col_off};
  assign row     = {2'b00, base_y} + {1'b0, row_off};
  assign last    = active && col_end && row_end;

  always_ff @(posedge clk) begin
    if (reset) begin
      col_off <= '0;
      row_off <= '0;
      active  <= 1'b0;
    end else if (go) begin
      col_off <= '0;
      row_off <= '0;
      active  <= 1'b1;
    end else if (active) begin
      if (col_end) begin
        col_off <= '0;
        if (row_end) begin
          row_off <= '0;
          active  <= 1'b0;
        end else begin
          row_off <= row_off + 8'd1;
        end
      end else begin
        col_off <= col_off + 8'd1;
      end
    end
  end
endmodule

// File: rtl/block_drawer.sv
// Redraws a moving block: erases the previous rectangle in the background colour,
// then draws the new one, streaming one registered pixel per cycle to the VGA adapter.
module block_drawer
  import tob_pkg::*;
#(
  parameter int         BLOCK_H   = BLOCK_H_DEF,
  parameter int         SCREEN_W  = SCREEN_COLS,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  logic [7:0] width_in,
  input  logic [2:0] colour_in,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       busy,
  output logic       done,
  output logic [1:0] state_dbg
);
  localparam logic [8:0] COL_LIM = 9'(SCREEN_W);
  localparam logic [8:0] ROW_LIM = 9'(SCREEN_ROWS);
  localparam logic [7:0] HEIGHT  = 8'(BLOCK_H);

  state_t     state, state_next;
  logic       capture, commit, scan_go;
  logic [7:0] new_x, prev_x, new_w, prev_w;
  logic [6:0] new_y, prev_y;
  logic [2:0] new_colour;
  logic       prev_valid;
  logic [7:0] scan_x, scan_w;
  logic [6:0] scan_y;
  logic [8:0] scan_col, scan_row;
  logic       scan_active, scan_last;

  assign busy      = (state != IDLE);
  assign done      = (state == FINISH);
  assign state_dbg = state;

  // The single scanner serves both phases; its geometry follows the current state.
  assign scan_x = (state == ERASE) ? prev_x : new_x;
  assign scan_y = (state == ERASE) ? prev_y : new_y;
  assign scan_w = (state == ERASE) ? prev_w : new_w;

  rect_scanner u_scan (
    .clk    (clk),
    .reset  (reset),
    .go     (scan_go),
    .base_x (scan_x),
    .base_y (scan_y),
    .width  (scan_w),
    .height (HEIGHT),
    .col    (scan_col),
    .row    (scan_row),
    .active (scan_active),
    .last   (scan_last)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // The first cycle of a redraw loads the scanner; ERASE hands over to DRAW
  // by reloading on its last pixel so the two scans run back to back.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    commit     = 1'b0;
    scan_go    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture    = 1'b1;
          state_next = (prev_valid && prev_w != 8'd0) ? ERASE : DRAW;
        end
      end
      ERASE: begin
        if (!scan_active) begin
          scan_go = 1'b1;
        end else if (scan_last) begin
          state_next = DRAW;
          scan_go    = (new_w != 8'd0);
        end
      end
      DRAW: begin
        if (new_w == 8'd0)       state_next = FINISH;
        else if (!scan_active)   scan_go    = 1'b1;
        else if (scan_last)      state_next = FINISH;
      end
      FINISH: begin
        commit     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      new_x      <= '0;
      new_y      <= '0;
      new_w      <= '0;
      new_colour <= '0;
      prev_x     <= '0;
      prev_y     <= '0;
      prev_w     <= '0;
      prev_valid <= 1'b0;
    end else begin
      if (capture) begin
        new_x      <= x_in;
        new_y      <= y_in;
        new_w      <= width_in;
        new_colour <= colour_in;
      end
      if (commit) begin
        prev_x     <= new_x;
        prev_y     <= new_y;
        prev_w     <= new_w;
        prev_valid <= 1'b1;
      end
    end
  end

  // Off-screen pixels still take their cycle but never strobe plot.
  always_ff @(posedge clk) begin
    if (reset) begin
      plot       <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
    end else begin
      plot       <= scan_active && (scan_col < COL_LIM) && (scan_row < ROW_LIM);
      vga_x      <= scan_col[7:0];
      vga_y      <= scan_row[6:0];
      vga_colour <= (state == ERASE) ? BG_COLOUR : new_colour;
    end
  end
endmodule

// File: tb/tb_block_drawer.sv
// Directed bench for block_drawer: redraw timing, pixel streams, clipping, start/reset corner cases.
module tb_block_drawer;
  logic       clk = 1'b0;
  logic       reset, start;
  logic [7:0] x_in, width_in;
  logic [6:0] y_in;
  logic [2:0] colour_in;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot, busy, done;
  logic [1:0] state_dbg;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [17:0] exp_q[$];
  logic [17:0] obs_q[$];

  block_drawer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .x_in       (x_in),
    .y_in       (y_in),
    .width_in   (width_in),
    .colour_in  (colour_in),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .plot       (plot),
    .busy       (busy),
    .done       (done),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  always #10 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic reset_dut();
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_rect(input int x, input int y, input int w, input logic [2:0] c);
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < w; k++)
        if (x + k < 160 && y + r < 120)
          exp_q.push_back({8'(x + k), 7'(y + r), c});
  endtask

  task automatic compare_pixels(input string tag);
    logic [17:0] o;
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      o = (i < obs_q.size()) ? obs_q[i] : 18'hx;
      check({tag, "_pix"}, o, exp_q[i]);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  // driver: one redraw, collecting plots until done; hold keeps start high throughout
  task automatic do_redraw(input logic [7:0] x, input logic [6:0] y, input logic [7:0] w,
                           input logic [2:0] c, input bit hold, input int exp_done,
                           input string tag);
    int done_cyc = -1;
    bit busy_ok  = 1'b1;
    obs_q.delete();
    @(negedge clk);
    x_in = x; y_in = y; width_in = w; colour_in = c; start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    x_in      = 8'($urandom_range(0, 255));
    y_in      = 7'($urandom_range(0, 127));
    width_in  = 8'($urandom_range(0, 255));
    colour_in = 3'($urandom_range(0, 7));
    for (int k = 1; k <= 400; k++) begin
      if (plot) obs_q.push_back({vga_x, vga_y, vga_colour});
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        done_cyc = k;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    check({tag, "_done_pulse"}, {busy, done}, 2'b00);
    start = 1'b0;
    check({tag, "_done_cycle"}, done_cyc, exp_done);
    check({tag, "_busy_held"}, busy_ok, 1'b1);
    compare_pixels(tag);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    x_in = '0; y_in = '0; width_in = '0; colour_in = '0;
    reset_dut();

    // reset state
    check("rst_plot", plot, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_vga", {vga_x, vga_y, vga_colour}, 18'h0);
    check("rst_state", state_dbg, 2'd0);

    // first draw, no erase
    push_rect(10, 100, 3, 3'b101);
    do_redraw(8'd10, 7'd100, 8'd3, 3'b101, 1'b0, 14, "first");

    // move right by one: erase then draw
    push_rect(10, 100, 3, 3'b000);
    push_rect(11, 100, 3, 3'b101);
    do_redraw(8'd11, 7'd100, 8'd3, 3'b101, 1'b0, 26, "move");

    // right-edge clipping
    reset_dut();
    push_rect(158, 100, 4, 3'b101);
    do_redraw(8'd158, 7'd100, 8'd4, 3'b101, 1'b0, 18, "clip_x");

    // start held high for the whole redraw, including the FINISH cycle
    push_rect(158, 100, 4, 3'b000);
    push_rect(20, 10, 2, 3'b011);
    do_redraw(8'd20, 7'd10, 8'd2, 3'b011, 1'b1, 26, "hold");

    // reset while DRAW is scanning its fifth pixel
    reset_dut();
    @(negedge clk);
    x_in = 8'd30; y_in = 7'd20; width_in = 8'd3; colour_in = 3'b110; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (plot) obs_q.push_back({vga_x, vga_y, vga_colour});
      if (k < 6) @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    check("abort_plot", plot, 1'b0);
    check("abort_state", {busy, state_dbg}, 3'b000);
    reset = 1'b0;
    exp_q.push_back({8'd30, 7'd20, 3'b110});
    exp_q.push_back({8'd31, 7'd20, 3'b110});
    exp_q.push_back({8'd32, 7'd20, 3'b110});
    exp_q.push_back({8'd30, 7'd21, 3'b110});
    compare_pixels("abort");
    repeat (3) begin
      @(negedge clk);
      check("abort_quiet", plot, 1'b0);
    end
    push_rect(40, 50, 3, 3'b010);
    do_redraw(8'd40, 7'd50, 8'd3, 3'b010, 1'b0, 14, "after_abort");

    // zero width, nothing valid before
    reset_dut();
    do_redraw(8'd5, 7'd5, 8'd0, 3'b111, 1'b0, 2, "zero_w");

    // previous block had zero width, so no erase; rows 120+ clipped
    push_rect(0, 118, 2, 3'b001);
    do_redraw(8'd0, 7'd118, 8'd2, 3'b001, 1'b0, 10, "clip_y");

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
